// File: rtl/rv32i_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle control path.
// Contents: supported opcode constants, FSM state encoding, alu_op / pc_src /
// wb_sel codes, the one-hot opcode class record and a helper that maps an
// opcode class to its write-back source. The datapath imports the same codes.
package rv32i_ctrl_pkg;

    // Supported base opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // FETCH is all-zero so the debug state port reads FETCH while in reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_RFUNCT = 4'd1;
    localparam logic [3:0] ALU_IFUNCT = 4'd2;
    localparam logic [3:0] ALU_BRCMP  = 4'd3;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // One-hot instruction class; all-zero means unsupported opcode
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic lui;
        logic jal;
    } opclass_t;

    // Register-file write source for an instruction class
    function automatic logic [1:0] wb_sel_for(input opclass_t cls);
        logic [1:0] sel;
        if (cls.load) begin
            sel = WB_MEM;
        end else if (cls.jal) begin
            sel = WB_PC4;
        end else if (cls.lui) begin
            sel = WB_IMM;
        end else begin
            sel = WB_ALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/opclass_decode.sv
// Opcode classifier.
// Ports: opcode (7b, from IR) in; opclass (one-hot class record) and
// supported (opcode is one of the seven handled classes) out. Pure logic.
module opclass_decode
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass,
    output logic       supported
);

    // Map opcode to its one-hot class; unknown opcodes leave every bit clear
    always_comb begin
        opclass = 7'b0;
        case (opcode)
            OPC_R:      opclass.r      = 1'b1;
            OPC_I:      opclass.i      = 1'b1;
            OPC_LOAD:   opclass.load   = 1'b1;
            OPC_STORE:  opclass.store  = 1'b1;
            OPC_BRANCH: opclass.branch = 1'b1;
            OPC_LUI:    opclass.lui    = 1'b1;
            OPC_JAL:    opclass.jal    = 1'b1;
            default:    opclass        = 7'b0;
        endcase
        supported = |opclass;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I subset control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Inputs: clk, rst_n (async, active-low), opcode (from IR), branch_taken
// (ALU compare), mem_ready (memory completes the pending request).
// Outputs: mem_req/mem_we/mem_addr_sel memory control, ir_write, pc_write,
// pc_src, reg_write, wb_sel, alu_src, alu_op, illegal (sticky trap flag) and
// state (debug). Outputs decode from state and opcode; mem_ready reaches only
// ir_write/pc_write and branch_taken only pc_src.
module multicycle_ctrl
    import rv32i_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic [3:0] alu_op,
    output logic       illegal,
    output logic [2:0] state
);

    state_e   state_q;
    state_e   state_d;
    opclass_t cls_s;
    logic     supported_s;

    opclass_decode u_opclass_decode (
        .opcode    (opcode),
        .opclass   (cls_s),
        .supported (supported_s)
    );

    // State register; reset returns to FETCH from anywhere, also leaving TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        illegal      = 1'b0;
        // While reset is asserted every strobe stays low, including the
        // fetch request that the FETCH state would otherwise raise.
        if (!rst_n) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        state_d  = S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (supported_s) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (cls_s.r) begin
                        alu_op  = ALU_RFUNCT;
                        state_d = S_WB;
                    end else if (cls_s.i) begin
                        alu_src = 1'b1;
                        alu_op  = ALU_IFUNCT;
                        state_d = S_WB;
                    end else if (cls_s.load || cls_s.store) begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_d = S_MEM;
                    end else if (cls_s.branch) begin
                        alu_op   = ALU_BRCMP;
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
                        state_d  = S_FETCH;
                    end else if (cls_s.lui || cls_s.jal) begin
                        state_d = S_WB;
                    end else begin
                        // IR changed to an unsupported opcode after DECODE
                        state_d = S_TRAP;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = cls_s.store;
                    if (mem_ready) begin
                        if (cls_s.store) begin
                            // A store retires here: its single PC update
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d  = S_WB;
                        end
                    end else begin
                        state_d = S_MEM;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    wb_sel    = wb_sel_for(cls_s);
                    pc_src    = cls_s.jal ? PC_JUMP : PC_PLUS4;
                    state_d   = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle comparison of every output against a
// trace model built from the instruction-level rules, instruction-level
// aggregates (latency, write counts, selects) checked against a table, random
// instruction streams, and hand-written reset/trap sequences.
module tb_multicycle_ctrl;
    import rv32i_ctrl_pkg::*;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_LUI = 7'b0110111;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       illegal;
    logic [2:0] state;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .state        (state)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the full expected output vector
    typedef struct packed {
        logic        mr;
        logic        bt;
        logic [6:0]  op;
        logic [18:0] exp;
    } cyc_t;

    // Instruction-level expectations
    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        logic       bt;
        int         lat;
        int         nregw;
        logic [1:0] pcs;
        logic [1:0] wb;
    } tv_t;

    cyc_t trace_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   obs_cnt, obs_lat, obs_regw, obs_pcw;
    logic [1:0] obs_pcs, obs_wb;

    function automatic logic [18:0] mk(input logic [2:0] st, input logic mreq,
        input logic mwe, input logic asel, input logic irw, input logic pcw,
        input logic [1:0] pcs, input logic regw, input logic [1:0] wb,
        input logic asrc, input logic [3:0] aop, input logic ill);
        return {st, mreq, mwe, asel, irw, pcw, pcs, regw, wb, asrc, aop, ill};
    endfunction

    function automatic logic [18:0] dut_out();
        return {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                pc_src, reg_write, wb_sel, alu_src, alu_op, illegal};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_vec(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic mr, input logic bt, input logic [6:0] op, input logic [18:0] e);
        cyc_t c;
        c.mr  = mr;
        c.bt  = bt;
        c.op  = op;
        c.exp = e;
        trace_q.push_back(c);
    endtask

    // Reference model: expected cycle trace of one instruction. fw/mw are
    // wait cycles before mem_ready in FETCH/MEM; for an unsupported opcode mw
    // is the number of TRAP cycles to observe.
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic bt);
        logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal, ok, asrc;
        logic [3:0] aop;
        logic [1:0] wb;
        is_r   = (op == T_R);
        is_i   = (op == T_I);
        is_ld  = (op == T_LD);
        is_st  = (op == T_ST);
        is_br  = (op == T_BR);
        is_lui = (op == T_LUI);
        is_jal = (op == T_JAL);
        ok     = is_r | is_i | is_ld | is_st | is_br | is_lui | is_jal;
        for (int k = 0; k < fw; k++)
            push(1'b0, rb(), 7'($urandom), mk(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0));
        push(1'b1, rb(), 7'($urandom), mk(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0));
        push(rb(), rb(), op, mk(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0));
        if (!ok) begin
            for (int k = 0; k < mw; k++)
                push(rb(), rb(), op, mk(S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b1));
        end else if (is_br) begin
            push(rb(), bt, op, mk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bt ? 2'b01 : 2'b00, 1'b0, 2'b00, 1'b0, 4'd3, 1'b0));
        end else begin
            aop  = is_r ? 4'd1 : (is_i ? 4'd2 : 4'd0);
            asrc = is_i | is_ld | is_st;
            push(rb(), rb(), op, mk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, asrc, aop, 1'b0));
            if (is_ld || is_st) begin
                for (int k = 0; k < mw; k++)
                    push(1'b0, rb(), op, mk(S_MEM, 1'b1, is_st, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0));
                push(1'b1, rb(), op, mk(S_MEM, 1'b1, is_st, 1'b1, 1'b0, is_st, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0));
            end
            if (!is_st) begin
                wb = is_ld ? 2'b01 : (is_jal ? 2'b10 : (is_lui ? 2'b11 : 2'b00));
                push(rb(), rb(), op, mk(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, is_jal ? 2'b10 : 2'b00, 1'b1, wb, 1'b0, 4'd0, 1'b0));
            end
        end
    endtask

    task automatic clear_obs();
        obs_cnt  = 0;
        obs_lat  = 0;
        obs_regw = 0;
        obs_pcw  = 0;
        obs_pcs  = 2'b00;
        obs_wb   = 2'b00;
    endtask

    // Apply up to max_cyc queued cycles, comparing outputs away from posedge
    task automatic run(input int max_cyc);
        cyc_t c;
        int   n = 0;
        while (trace_q.size() > 0 && n < max_cyc) begin
            c = trace_q.pop_front();
            @(negedge clk);
            mem_ready    = c.mr;
            branch_taken = c.bt;
            opcode       = c.op;
            #1;
            check_vec($sformatf("trace op=%b cyc=%0d", c.op, obs_cnt + 1), dut_out(), c.exp);
            obs_cnt++;
            if (pc_write) begin
                obs_pcw++;
                if (obs_lat == 0) obs_lat = obs_cnt;
                obs_pcs = pc_src;
            end
            if (reg_write) begin
                obs_regw++;
                obs_wb = wb_sel;
            end
            n++;
        end
    endtask

    tv_t tab[10];
    logic [6:0] ops[7];
    logic [18:0] zero_fetch, fetch_req;

    initial begin
        //        op     fw mw bt    lat nregw pcs    wb
        tab[0] = '{T_R,   0, 0, 1'b0, 4, 1, 2'b00, 2'b00};
        tab[1] = '{T_I,   1, 0, 1'b1, 5, 1, 2'b00, 2'b00};
        tab[2] = '{T_LD,  0, 3, 1'b0, 8, 1, 2'b00, 2'b01};
        tab[3] = '{T_LD,  0, 0, 1'b0, 5, 1, 2'b00, 2'b01};
        tab[4] = '{T_ST,  0, 0, 1'b0, 4, 0, 2'b00, 2'b00};
        tab[5] = '{T_ST,  2, 1, 1'b1, 7, 0, 2'b00, 2'b00};
        tab[6] = '{T_BR,  0, 0, 1'b1, 3, 0, 2'b01, 2'b00};
        tab[7] = '{T_BR,  0, 0, 1'b0, 3, 0, 2'b00, 2'b00};
        tab[8] = '{T_JAL, 0, 0, 1'b0, 4, 1, 2'b10, 2'b10};
        tab[9] = '{T_LUI, 0, 0, 1'b0, 4, 1, 2'b00, 2'b11};
        ops = '{T_R, T_I, T_LD, T_ST, T_BR, T_LUI, T_JAL};
        zero_fetch = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
        fetch_req  = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);

        // Reset: everything low even with mem_ready high
        rst_n = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; opcode = T_R;
        #2 rst_n = 1'b0;
        #10;
        check_vec("reset_outputs", dut_out(), zero_fetch);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        check_vec("post_reset_fetch", dut_out(), fetch_req);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            clear_obs();
            build(tab[i].op, tab[i].fw, tab[i].mw, tab[i].bt);
            run(100);
            check_int($sformatf("tab%0d_latency", i), obs_lat, tab[i].lat);
            check_int($sformatf("tab%0d_pc_writes", i), obs_pcw, 1);
            check_int($sformatf("tab%0d_reg_writes", i), obs_regw, tab[i].nregw);
            check_int($sformatf("tab%0d_pc_src", i), int'(obs_pcs), int'(tab[i].pcs));
            if (tab[i].nregw > 0)
                check_int($sformatf("tab%0d_wb_sel", i), int'(obs_wb), int'(tab[i].wb));
        end

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            clear_obs();
            build(ops[$urandom_range(0, 6)], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
            run(100);
            check_int("rand_pc_writes", obs_pcw, 1);
        end

        // Store interrupted by reset while its request is pending
        clear_obs();
        build(T_ST, 0, 5, 1'b0);
        run(5);
        trace_q.delete();
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_vec("rst_mid_mem_outputs", dut_out(), zero_fetch);
        @(posedge clk);
        #1;
        check_vec("rst_mid_mem_held", dut_out(), zero_fetch);
        check_int("rst_mid_mem_pc_writes", obs_pcw + int'(pc_write), 0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check_vec("rst_mid_mem_release", dut_out(), fetch_req);

        // A normal instruction after the interrupted store
        clear_obs();
        build(T_R, 0, 0, 1'b0);
        run(100);
        check_int("after_rst_latency", obs_lat, 4);

        // Unsupported opcode traps for good until reset
        clear_obs();
        build(T_BAD, 0, 100, 1'b0);
        run(200);
        check_int("trap_pc_writes", obs_pcw, 0);
        check_int("trap_reg_writes", obs_regw, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("trap_reset_outputs", dut_out(), zero_fetch);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check_vec("trap_cleared", dut_out(), fetch_req);
        check_int("trap_illegal_clear", int'(illegal), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
